alu_seq: RTL and testbench

- Parametrised, registered ALU for the next datapath revision.
- Operand width is set by WIDTH. Adds SUB, shift-left, arithmetic shift-right and multiply, plus CARRY/OVERFLOW flags.
- Single-cycle ops complete in 1 clock. Shifts and multiply run iteratively under a START/BUSY/DONE handshake.
- Sits between the register file read ports and the write-back mux. The controller stalls the PC while BUSY is high.

---
 rtl/alu_seq.sv | 213 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle FWD/ADD/AND/OR/SUB; iterative SLL/SRA (n cycles) and MUL (WIDTH cycles).
// BUSY is high while an iterative op runs, and START is ignored then; DONE pulses once per accepted op.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic                 sra_q, sra_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;

  logic [WIDTH:0]       add_full;
  logic [WIDTH:0]       sub_full;
  logic                 add_ovf;
  logic                 sub_ovf;
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     work_shift;
  logic                 shift_out;
  logic [2*WIDTH-1:0]   acc_next;

  assign add_full = {1'b0, DATA1} + {1'b0, DATA2};
  assign sub_full = {1'b0, DATA1} - {1'b0, DATA2};
  assign add_ovf  = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (add_full[WIDTH-1] != DATA1[WIDTH-1]);
  assign sub_ovf  = (DATA1[WIDTH-1] != DATA2[WIDTH-1]) && (sub_full[WIDTH-1] != DATA1[WIDTH-1]);
  assign shamt    = DATA2[SHW-1:0];

  // One bit per cycle; the bit falling off the end becomes CARRY on the final step.
  assign work_shift = sra_q ? {work_q[WIDTH-1], work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};
  assign shift_out  = sra_q ? work_q[0] : work_q[WIDTH-1];
  assign acc_next   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    work_d   = work_q;
    sra_d    = sra_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          case (SELECT)
            3'b000: begin
              result_d = DATA2;
              carry_d  = 1'b0;
              ovf_d    = 1'b0;
              done_d   = 1'b1;
            end
            3'b001: begin
              result_d = add_full[WIDTH-1:0];
              carry_d  = add_full[WIDTH];
              ovf_d    = add_ovf;
              done_d   = 1'b1;
            end
            3'b010: begin
              result_d = DATA1 & DATA2;
              carry_d  = 1'b0;
              ovf_d    = 1'b0;
              done_d   = 1'b1;
            end
            3'b011: begin
              result_d = DATA1 | DATA2;
              carry_d  = 1'b0;
              ovf_d    = 1'b0;
              done_d   = 1'b1;
            end
            3'b100: begin
              result_d = sub_full[WIDTH-1:0];
              carry_d  = ~sub_full[WIDTH];
              ovf_d    = sub_ovf;
              done_d   = 1'b1;
            end
            3'b101, 3'b110: begin
              if (shamt == '0) begin
                result_d = DATA1;
                carry_d  = 1'b0;
                ovf_d    = 1'b0;
                done_d   = 1'b1;
              end else begin
                work_d  = DATA1;
                sra_d   = SELECT[1];
                cnt_d   = {1'b0, shamt};
                busy_d  = 1'b1;
                state_d = SHIFT;
              end
            end
            default: begin
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, DATA1};
              mplier_d = DATA2;
              cnt_d    = CW'(WIDTH);
              busy_d   = 1'b1;
              state_d  = MUL;
            end
          endcase
        end
      end

      SHIFT: begin
        work_d = work_shift;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = work_shift;
          carry_d  = shift_out;
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = acc_next[WIDTH-1:0];
          carry_d  = 1'b0;
          ovf_d    = |acc_next[2*WIDTH-1:WIDTH];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (done_d) begin
      zero_d = (result_d == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      work_q   <= '0;
      sra_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      sra_q    <= sra_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign RESULT   = result_q;
  assign ZERO     = zero_q;
  assign CARRY    = carry_q;
  assign OVERFLOW = ovf_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed ops push expected results into a scoreboard;
// a monitor pops one entry per DONE pulse and also checks the edge on which it arrived.
module tb_alu_seq;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic [2:0]   SELECT;
  logic [W-1:0] DATA1;
  logic [W-1:0] DATA2;
  logic [W-1:0] RESULT;
  logic         ZERO;
  logic         CARRY;
  logic         OVERFLOW;
  logic         BUSY;
  logic         DONE;

  alu_seq #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .SELECT   (SELECT),
    .DATA1    (DATA1),
    .DATA2    (DATA2),
    .RESULT   (RESULT),
    .ZERO     (ZERO),
    .CARRY    (CARRY),
    .OVERFLOW (OVERFLOW),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   edge_cnt = 0;
  int   n_total  = 0;
  int   n_pass   = 0;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: DONE=1 with no op pending at edge %0d, expected DONE=0", edge_cnt);
        end else begin
          mon_e = sb.pop_front();
          chk("result",    32'(RESULT),   32'(mon_e.res));
          chk("zero",      32'(ZERO),     32'(mon_e.res == '0));
          chk("carry",     32'(CARRY),    32'(mon_e.c));
          chk("overflow",  32'(OVERFLOW), 32'(mon_e.v));
          chk("done_edge", edge_cnt,      mon_e.due);
        end
      end
    end
  end

  // extra = cycles beyond the accepting edge before DONE (0 for single-cycle ops).
  task automatic issue(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic c, input logic v, input int extra);
    exp_t e;
    START  = 1'b1;
    SELECT = sel;
    DATA1  = a;
    DATA2  = b;
    e.res  = res;
    e.c    = c;
    e.v    = v;
    e.due  = edge_cnt + 1 + extra;
    sb.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int nb;
    RESET  = 1'b1;
    START  = 1'b0;
    SELECT = 3'b000;
    DATA1  = '0;
    DATA2  = '0;
    repeat (2) @(negedge CLK);
    chk("rst_result",   32'(RESULT),   32'h0);
    chk("rst_zero",     32'(ZERO),     32'h1);
    chk("rst_carry",    32'(CARRY),    32'h0);
    chk("rst_overflow", 32'(OVERFLOW), 32'h0);
    chk("rst_busy",     32'(BUSY),     32'h0);
    chk("rst_done",     32'(DONE),     32'h0);
    RESET = 1'b0;
    @(negedge CLK);

    issue(3'b001, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0);
    START = 1'b0;
    chk("add_busy", 32'(BUSY), 32'h0);
    @(negedge CLK);

    // Back-to-back single-cycle ops with START held high.
    issue(3'b100, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 0);
    issue(3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
    issue(3'b100, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 0);
    issue(3'b100, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 0);
    issue(3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 0);
    issue(3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 0);
    issue(3'b000, 8'h11, 8'hA5, 8'hA5, 1'b0, 1'b0, 0);
    START = 1'b0;
    @(negedge CLK);

    issue(3'b101, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 3);
    START = 1'b0;
    wait_idle(nb);
    chk("sll3_busy_cycles", nb, 3);
    issue(3'b110, 8'h81, 8'h01, 8'hC0, 1'b1, 1'b0, 1);
    START = 1'b0;
    wait_idle(nb);
    chk("sra1_busy_cycles", nb, 1);
    issue(3'b110, 8'h8E, 8'h02, 8'hE3, 1'b1, 1'b0, 2);
    START = 1'b0;
    wait_idle(nb);
    chk("sra2_busy_cycles", nb, 2);
    // Only DATA2[2:0] is the shift amount: 0xFF shifts by 7.
    issue(3'b101, 8'h03, 8'hFF, 8'h80, 1'b1, 1'b0, 7);
    START = 1'b0;
    wait_idle(nb);
    chk("sll7_busy_cycles", nb, 7);
    issue(3'b101, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 0);
    START = 1'b0;
    chk("sll0_busy", 32'(BUSY), 32'h0);
    @(negedge CLK);

    // MUL with a START pulse and operand change while busy; both must be ignored.
    issue(3'b111, 8'h10, 8'h11, 8'h10, 1'b0, 1'b1, 8);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    START  = 1'b1;
    SELECT = 3'b001;
    DATA1  = 8'h01;
    DATA2  = 8'h01;
    @(negedge CLK);
    START = 1'b0;
    DATA1 = 8'hAA;
    wait_idle(nb);
    chk("mul_busy_cycles", nb + 3, 8);
    issue(3'b111, 8'h0F, 8'h03, 8'h2D, 1'b0, 1'b0, 8);
    START = 1'b0;
    wait_idle(nb);
    chk("mul2_busy_cycles", nb, 8);
    @(negedge CLK);

    // Reset during the 4th MUL cycle discards the op without a DONE.
    issue(3'b111, 8'h10, 8'h11, 8'h10, 1'b0, 1'b1, 8);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    sb.delete();
    @(negedge CLK);
    RESET = 1'b0;
    chk("midrst_busy",     32'(BUSY),     32'h0);
    chk("midrst_result",   32'(RESULT),   32'h0);
    chk("midrst_zero",     32'(ZERO),     32'h1);
    chk("midrst_done",     32'(DONE),     32'h0);
    chk("midrst_overflow", 32'(OVERFLOW), 32'h0);
    issue(3'b000, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 0);
    START = 1'b0;

    repeat (12) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1);
  end

endmodule
